// File: rtl/window_buffer_2d.sv
// window_buffer_2d: KxK sliding-window generator for a raster-scan pixel stream.
// K-1 circular line buffers (indexed by column) feed a KxK window register that
// shifts left one column per accepted pixel. A window is flagged valid only once
// the window lies entirely inside the image (no padding, no line straddling).
module window_buffer_2d #(
  parameter int DATA_W = 12,
  parameter int K      = 5,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  localparam int XW    = $clog2(IMG_W),
  localparam int YW    = $clog2(IMG_H)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic                       sof,
  input  logic signed [DATA_W-1:0]   d_in,
  output logic                       win_valid,
  output logic [K*K*DATA_W-1:0]      win_data,
  output logic [XW-1:0]              win_x,
  output logic [YW-1:0]              win_y,
  output logic                       frame_done
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_KM1  = XW'(K - 1);
  localparam logic [YW-1:0] Y_KM1  = YW'(K - 1);

  logic [XW-1:0] col_cnt;
  logic [YW-1:0] row_cnt;

  // ---- stage p0: accept, pixel position, line-buffer read ----
  logic                     accept_p0;
  logic [XW-1:0]            col_p0;
  logic [YW-1:0]            row_p0;
  logic                     win_ok_p0;
  logic                     last_p0;
  logic signed [DATA_W-1:0] lb_rd_p0  [K-1];
  logic signed [DATA_W-1:0] col_vec_p0 [K];

  // sof forces the accepted pixel to (0,0) regardless of the running counters
  always_comb begin
    accept_p0 = en & in_valid;
    col_p0    = sof ? '0 : col_cnt;
    row_p0    = sof ? '0 : row_cnt;
    win_ok_p0 = (row_p0 >= Y_KM1) && (col_p0 >= X_KM1);
    last_p0   = (row_p0 == Y_LAST) && (col_p0 == X_LAST);
  end

  // Each line buffer is a separate RAM; line i+1 receives what line i held at this column
  for (genvar gi = 0; gi < K - 1; gi++) begin : g_lb
    logic signed [DATA_W-1:0] mem [IMG_W];

    assign lb_rd_p0[gi] = mem[col_p0];

    if (gi == 0) begin : g_first
      // newest stored line takes the incoming pixel
      always_ff @(posedge clk) begin
        if (accept_p0) mem[col_p0] <= d_in;
      end
    end else begin : g_chain
      // older lines take the previous line's old value (read-before-write)
      always_ff @(posedge clk) begin
        if (accept_p0) mem[col_p0] <= lb_rd_p0[gi-1];
      end
    end
  end

  // Column vector: row 0 = oldest line, row K-1 = current pixel
  always_comb begin
    for (int r = 0; r < K; r++) col_vec_p0[r] = '0;
    col_vec_p0[K-1] = d_in;
    for (int r = 0; r < K - 1; r++) col_vec_p0[r] = lb_rd_p0[K-2-r];
  end

  // ---- stage p1: window register and registered outputs ----
  logic signed [DATA_W-1:0] win_p1 [K][K];

  // Window register shifts left on every accept; new column enters on the right
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          win_p1[r][c] <= '0;
    end else if (accept_p0) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_p1[r][c] <= win_p1[r][c+1];
        win_p1[r][K-1] <= col_vec_p0[r];
      end
    end
  end

  // Position counters plus valid/coordinate/frame-done flags; en low freezes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
    end else if (en) begin
      if (in_valid) begin
        if (col_p0 == X_LAST) begin
          col_cnt <= '0;
          row_cnt <= (row_p0 == Y_LAST) ? '0 : row_p0 + 1'b1;
        end else begin
          col_cnt <= col_p0 + 1'b1;
          row_cnt <= row_p0;
        end
        win_valid  <= win_ok_p0;
        frame_done <= last_p0;
        if (win_ok_p0) begin
          win_x <= col_p0 - X_KM1;
          win_y <= row_p0 - Y_KM1;
        end
      end else begin
        win_valid  <= 1'b0;
        frame_done <= 1'b0;
      end
    end
  end

  // Flatten window: element (r,c) at [(r*K+c)*DATA_W +: DATA_W]
  always_comb begin
    win_data = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        win_data[(r*K+c)*DATA_W +: DATA_W] = win_p1[r][c];
  end

endmodule
